inst_fetch_buffer: RTL
======================

# inst_fetch_buffer

Instruction prefetch stage placed directly upstream of the single-cycle datapath's decode/execute logic. Reads the byte-organised instruction memory one byte per cycle, assembles big-endian 32-bit instructions, and queues them with their PC in a small FIFO. The execute stage pops instructions through a valid/ready handshake and redirects fetch on taken branches and jumps, which flushes the buffer.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- ADDR_W, 5, instruction-memory byte-address width (32-byte memory)
- RESET_PC, 32'h0, first fetch address; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_rd  out  1  byte read request, sampled by memory at rising edge
- imem_addr  out  ADDR_W  byte address of request
- imem_rdata  in  8  byte data, valid the cycle after the sampling edge
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  consumer accepts head
- inst  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- count  out  $clog2(DEPTH)+1  occupied entries
- flush_cnt  out  8  present only with IFB_FLUSH_CNT_EN

## Operation
- Reset values: inst_valid 0, count 0, inst 0, inst_pc 0, imem_rd 0, imem_addr 0, flush_cnt 0. Internal state: fetch_pc = RESET_PC, FSM in IDLE.
- FSM states:
  - IDLE: entered only by reset. Goes to ISSUE (k=0) on the first edge with rst_n high.
  - ISSUE: byte index k=0..3. imem_rd=1 and imem_addr=fetch_pc[ADDR_W-1:0]+k, modulo 2^ADDR_W, so addresses wrap.
  - HOLD: FIFO full at a word boundary. imem_rd=0.
- imem_rd and imem_addr are combinational from the FSM state.
- Assembly, big-endian:
  - Byte k returned lands in bits [31-8k -: 8] of the assembly register.
  - When byte 3 is captured, {word, fetch_pc} is pushed and fetch_pc increments by 4, modulo 2^32.
- Flow control: a new k=0 issue is allowed only if (count + push_this_cycle) < DEPTH. A pop in the same cycle is not credited. Otherwise the FSM moves to HOLD. HOLD goes to ISSUE k=0 on the first cycle the condition holds.
- Because of this rule a push never finds the FIFO full.
- Pop: occurs when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
- inst and inst_pc show the head entry and hold their value while inst_valid=0.
- Redirect has priority over every other event on that edge:
  - FIFO cleared to count 0.
  - The partial word is abandoned.
  - The byte returned in the next cycle is discarded (in-flight kill flag).
  - A push occurring on the same edge is dropped.
  - A pop on the same edge is still a completed handshake for the consumer.
  - fetch_pc becomes {redirect_pc[31:2],2'b00} and the FSM enters ISSUE k=0, also from HOLD or IDLE.
- Redirect during reset has no effect. Asserting rst_n mid-word returns all state to the reset values immediately; no partial word survives.

## Timing
- E0 is the first rising edge with rst_n high. Requests k=0..3 are sampled at E1..E4, bytes are captured at E2..E5, and the word is pushed at E5. inst_valid is high after E5.
- Steady state: one instruction every 4 cycles, because the k=0 issue overlaps the byte-3 capture.
- Redirect at edge Er: first request sampled at Er+1, first new word pushed at Er+5, inst_valid low from Er until Er+5.
- Push at edge E makes inst_valid visible after E; zero-cycle bypass is not provided.

## Configuration
- IFB_FLUSH_CNT_EN defined:
  - flush_cnt port exists.
  - Increments by 1 on each redirect that discards at least one FIFO entry or an in-progress word (k>0 or a byte in flight).
  - Saturates at 255 and resets to 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset then run: imem bytes 0..7 = 8C 01 00 04 AC 22 00 08, inst_ready=1. Required:
  - inst=32'h8C010004, inst_pc=0 valid after E5.
  - inst=32'hAC220008, inst_pc=4 valid after E9.
- Backpressure: inst_ready=0 with DEPTH=4. Required:
  - count reaches 4 and the FSM sits in HOLD with imem_rd=0.
  - Raising inst_ready drains PCs 0,4,8,12 in order, and fetch resumes at PC 16.
- Wrap: RESET_PC=32'h1C. Required: the second word's requests use addresses 0,1,2,3 and inst_pc=32'h20.
- Mid-word redirect: redirect=1, redirect_pc=32'h0000000E during k=2 of the word at PC 4. Required:
  - count=0 and the in-flight byte is discarded.
  - The next inst_pc is 32'h0C, pushed at Er+5.
  - With IFB_FLUSH_CNT_EN, flush_cnt=1.
- Simultaneous events: redirect on the same edge as a byte-3 push and an accepted pop. Required: the pushed word is dropped, count=0, and the popped word counts as consumed.
- Async reset with count=3 mid-word. Required: all outputs return to their reset values immediately, and restart follows the E0..E5 timing.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Byte-serial instruction prefetch: assembles big-endian words from imem into a small FIFO.
// Latency: first word is pushed 5 edges after fetch starts or restarts; 1 word per 4 cycles steady.
// Backpressure: valid/ready pop; fetch parks in HOLD at a word boundary when the FIFO cannot take another word.
//
// Ports: clk/rst_n (async active-low); imem_rd/imem_addr/imem_rdata byte read port
// (data valid the cycle after the request edge); redirect/redirect_pc flush + restart;
// inst_valid/inst_ready/inst/inst_pc FIFO head handshake; count FIFO occupancy.
// Optional macro IFB_FLUSH_CNT_EN adds flush_cnt, a saturating count of redirects
// that threw away buffered or partially fetched work.
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_rd,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [7:0]               imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFB_FLUSH_CNT_EN
  ,
  output logic [7:0]               flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;               // byte index of the request being issued
  logic [ADDR_W-1:0] issue_addr_q, issue_addr_d; // word base address of the requests
  logic [31:0]       fetch_pc_q, fetch_pc_d;     // PC of the word being assembled
  logic [23:0]       asm_q, asm_d;           // bytes 0..2 of the word under assembly
  logic              inflight_q, inflight_d; // a byte returns this cycle
  logic [1:0]        inflight_k_q, inflight_k_d;
  logic [31:0]       mem_inst_q [DEPTH];
  logic [31:0]       mem_inst_d [DEPTH];
  logic [31:0]       mem_pc_q   [DEPTH];
  logic [31:0]       mem_pc_d   [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic              push, pop;
  logic [31:0]       push_word;

  assign inst_valid = (count_q != '0);
  assign count      = count_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    issue_addr_d = issue_addr_q;
    fetch_pc_d   = fetch_pc_q;
    asm_d        = asm_q;
    inflight_d   = (state_q == S_ISSUE);
    inflight_k_d = k_q;
    mem_inst_d   = mem_inst_q;
    mem_pc_d     = mem_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    push         = 1'b0;
    pop          = inst_valid && inst_ready;
    push_word    = {asm_q, imem_rdata};

    imem_rd   = (state_q == S_ISSUE);
    imem_addr = imem_rd ? (issue_addr_q + ADDR_W'(k_q)) : '0;

    // Byte capture; a redirect on this edge kills the returning byte.
    if (inflight_q && !redirect) begin
      case (inflight_k_q)
        2'd0:    asm_d[23:16] = imem_rdata;
        2'd1:    asm_d[15:8]  = imem_rdata;
        2'd2:    asm_d[7:0]   = imem_rdata;
        default: push         = 1'b1;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
        k_d     = 2'd0;
      end
      S_ISSUE: begin
        if (k_q != 2'd3) begin
          k_d = k_q + 2'd1;
        end else begin
          k_d          = 2'd0;
          issue_addr_d = issue_addr_q + ADDR_W'(4);
          // The word just completed will push during the next k=0 cycle, so it is
          // counted here; a pop during that cycle is not credited.
          if (int'(count_q) + 1 < DEPTH) state_d = S_ISSUE;
          else                           state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (int'(count_q) + int'(push) < DEPTH) begin
          state_d = S_ISSUE;
          k_d     = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_inst_d[wr_ptr_q] = push_word;
      mem_pc_d[wr_ptr_q]   = fetch_pc_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
      fetch_pc_d           = fetch_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Registered head; the slot being written this edge is forwarded from push_word.
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        inst_d    = push_word;
        inst_pc_d = fetch_pc_q;
      end else begin
        inst_d    = mem_inst_q[rd_ptr_d];
        inst_pc_d = mem_pc_q[rd_ptr_d];
      end
    end

    if (redirect) begin
      state_d      = S_ISSUE;
      k_d          = 2'd0;
      issue_addr_d = redirect_pc[ADDR_W-1:0] & ~ADDR_W'(3);
      fetch_pc_d   = redirect_pc & ~32'h3;
      asm_d        = '0;
      inflight_d   = 1'b0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      issue_addr_q <= RESET_PC[ADDR_W-1:0];
      fetch_pc_q   <= RESET_PC;
      asm_q        <= '0;
      inflight_q   <= 1'b0;
      inflight_k_q <= '0;
      mem_inst_q   <= '{default: '0};
      mem_pc_q     <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      issue_addr_q <= issue_addr_d;
      fetch_pc_q   <= fetch_pc_d;
      asm_q        <= asm_d;
      inflight_q   <= inflight_d;
      inflight_k_q <= inflight_k_d;
      mem_inst_q   <= mem_inst_d;
      mem_pc_q     <= mem_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

`ifdef IFB_FLUSH_CNT_EN
  logic [7:0] flush_cnt_q, flush_cnt_d;

  // Only redirects that actually discard work are counted.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect && ((count_q != '0) || inflight_q || ((state_q == S_ISSUE) && (k_q != 2'd0)))
        && (flush_cnt_q != 8'hFF))
      flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_cnt_q <= '0;
    else        flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule
